// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  function automatic int clog2(input int value);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < value) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Shift-add-3 correction cell: digits of 5 and above get +3 before the next shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] result
);

  assign result = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, with optional
// two's-complement input, start/busy/done handshake and overflow detection.
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          sign_out,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_w;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [BIN_W-1:0] mag;
  logic [BIN_W-1:0] mag_shift;
  logic [BIN_W-1:0] neg_in;
  logic             is_neg;
  logic             sign_w;
  logic             ovf_w;
  logic             ovf_next;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .digit  (bcd_w[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .result (bcd_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  // The most negative input negates to itself, which read as unsigned is the correct magnitude.
  assign is_neg    = SIGNED && bin_in[BIN_W-1];
  assign neg_in    = ~bin_in + BIN_W'(1);
  assign bcd_shift = {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
  assign mag_shift = {mag[BIN_W-2:0], 1'b0};
  assign ovf_next  = ovf_w | bcd_adj[BCD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bcd_w    <= '0;
      mag      <= '0;
      sign_w   <= 1'b0;
      ovf_w    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      sign_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mag    <= is_neg ? neg_in : bin_in;
            sign_w <= is_neg;
            bcd_w  <= '0;
            ovf_w  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_w <= bcd_shift;
          mag   <= mag_shift;
          ovf_w <= ovf_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            bcd_out  <= bcd_shift;
            sign_out <= sign_w;
            overflow <= ovf_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
